// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the gated frequency counter front end:
// default gate length, BCD digit type, converter states and small helpers.
package freq_counter_pkg;

    localparam int GATE_CYCLES_DEFAULT = 1_000_000;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_LOAD
    } conv_state_t;

    // Double-dabble correction applied to each digit before every shift.
    function automatic bcd_digit_t add3_if_ge5(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/freq_gate_bcd_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, CNT_W shift cycles,
// then a single LOAD cycle in which done is high and bcd holds the result.
module bin2bcd_seq
    import freq_counter_pkg::*;
#(
    parameter int CNT_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int STEP_W = $clog2(CNT_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 1);

    conv_state_t          state;
    logic [CNT_W-1:0]     shift_reg;
    logic [STEP_W-1:0]    step;
    logic [4*DIGITS-1:0]  adjusted;
    logic                 spill_unused;

    always_comb begin
        adjusted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adjusted[4*i +: 4] = add3_if_ge5(bcd[4*i +: 4]);
        end
    end

    // The top adjusted bit only shifts out for values that the top level
    // already saturates, so it is intentionally discarded.
    assign spill_unused = adjusted[4*DIGITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CONV_IDLE;
            shift_reg <= '0;
            step      <= '0;
            bcd       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                CONV_IDLE: begin
                    if (start) begin
                        shift_reg <= bin;
                        bcd       <= '0;
                        step      <= '0;
                        state     <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    bcd       <= {adjusted[4*DIGITS-2:0], shift_reg[CNT_W-1]};
                    shift_reg <= shift_reg << 1;
                    step      <= step + STEP_W'(1);
                    if (step == LAST_STEP) begin
                        state <= CONV_LOAD;
                        done  <= 1'b1;
                    end
                end
                CONV_LOAD: begin
                    state <= CONV_IDLE;
                end
                default: begin
                    state <= CONV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/freq_gate_bcd.sv
// Gated frequency counter: synchronizes clk_x_in, counts its rising edges per
// gate window, converts the count to BCD and offers it on a valid/ready port.
module freq_gate_bcd
    import freq_counter_pkg::*;
#(
    parameter int REF_HZ      = 1_000_000,
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int CNT_W       = 20,
    parameter int DIGITS      = 6
) (
    input  logic                 clk_ref_in,
    input  logic                 reset_in,
    input  logic                 clk_x_in,
    output logic [4*DIGITS-1:0]  bcd_out,
    output logic                 overflow_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    localparam int TIMER_W = $clog2(GATE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam longint unsigned DEC_LIMIT = pow10(DIGITS);

    if (GATE_CYCLES <= CNT_W + 2) begin : g_gate_too_short
        $error("GATE_CYCLES must exceed CNT_W+2 so a capture only arrives in IDLE");
    end
    if (CNT_W < 64 && (64'd1 << CNT_W) < DEC_LIMIT) begin : g_cnt_too_narrow
        $error("CNT_W too narrow to hold 10^DIGITS");
    end
    if (REF_HZ < 2) begin : g_ref_too_slow
        $error("REF_HZ must be at least 2");
    end

    logic                 x_sync1;
    logic                 x_sync2;
    logic                 x_prev;
    logic                 edge_det;
    logic [TIMER_W-1:0]   gate_timer;
    logic                 terminal;
    logic [CNT_W-1:0]     edge_cnt;
    logic [CNT_W-1:0]     capture;
    logic                 capture_sat;
    logic                 sat_q;
    logic                 conv_done;
    logic [4*DIGITS-1:0]  conv_bcd;

    always_ff @(posedge clk_ref_in) begin
        if (reset_in) begin
            x_sync1 <= 1'b0;
            x_sync2 <= 1'b0;
            x_prev  <= 1'b0;
        end else begin
            x_sync1 <= clk_x_in;
            x_sync2 <= x_sync1;
            x_prev  <= x_sync2;
        end
    end

    assign edge_det = x_sync2 & ~x_prev;
    assign terminal = (gate_timer == TIMER_LAST);

    // An edge seen in the terminal cycle still belongs to the closing window.
    always_comb begin
        capture = edge_cnt;
        if (edge_det && edge_cnt != CNT_MAX) begin
            capture = edge_cnt + CNT_W'(1);
        end
    end

    assign capture_sat = (64'(capture) >= DEC_LIMIT);

    always_ff @(posedge clk_ref_in) begin
        if (reset_in) begin
            gate_timer <= '0;
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
        end else if (terminal) begin
            gate_timer <= '0;
            edge_cnt   <= '0;
            sat_q      <= capture_sat;
        end else begin
            gate_timer <= gate_timer + TIMER_W'(1);
            if (edge_det && edge_cnt != CNT_MAX) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

    bin2bcd_seq #(
        .CNT_W  (CNT_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk_ref_in),
        .reset (reset_in),
        .start (terminal),
        .bin   (capture),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Latest result wins: a new LOAD overwrites an unaccepted result.
    always_ff @(posedge clk_ref_in) begin
        if (reset_in) begin
            bcd_out      <= '0;
            overflow_out <= 1'b0;
            valid_out    <= 1'b0;
        end else if (conv_done) begin
            bcd_out      <= sat_q ? {DIGITS{4'h9}} : conv_bcd;
            overflow_out <= sat_q;
            valid_out    <= 1'b1;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_gate_bcd.sv
// Directed bench: a 100-cycle-gate instance driven with hand-timed patterns
// and a 2-digit instance that must saturate to 99.
module tb_freq_gate_bcd;

    logic        clk_ref;
    logic        reset_a;
    logic        reset_b;
    logic        clk_x_a;
    logic        clk_x_b;
    logic        ready_a;
    logic        ready_b;
    logic [23:0] bcd_a;
    logic [7:0]  bcd_b;
    logic        overflow_a;
    logic        overflow_b;
    logic        valid_a;
    logic        valid_b;

    int checks;
    int errors;
    int now;
    int gen_period;
    int gen_phase;

    freq_gate_bcd #(
        .REF_HZ      (1_000_000),
        .GATE_CYCLES (100),
        .CNT_W       (20),
        .DIGITS      (6)
    ) dut_a (
        .clk_ref_in   (clk_ref),
        .reset_in     (reset_a),
        .clk_x_in     (clk_x_a),
        .bcd_out      (bcd_a),
        .overflow_out (overflow_a),
        .valid_out    (valid_a),
        .ready_in     (ready_a)
    );

    freq_gate_bcd #(
        .REF_HZ      (1_000_000),
        .GATE_CYCLES (1000),
        .CNT_W       (10),
        .DIGITS      (2)
    ) dut_b (
        .clk_ref_in   (clk_ref),
        .reset_in     (reset_b),
        .clk_x_in     (clk_x_b),
        .bcd_out      (bcd_b),
        .overflow_out (overflow_b),
        .valid_out    (valid_b),
        .ready_in     (ready_b)
    );

    initial begin
        clk_ref = 1'b0;
        forever #5 clk_ref = ~clk_ref;
    end

    // Two reference cycles per period, edges kept 2 ns before the clock edge.
    initial begin
        clk_x_b = 1'b0;
        #3;
        forever #10 clk_x_b = ~clk_x_b;
    end

    // Periodic pattern for dut_a, updated on falling reference edges.
    initial begin
        forever begin
            @(negedge clk_ref);
            if (gen_period != 0) begin
                clk_x_a   = (gen_phase < gen_period / 2);
                gen_phase = (gen_phase + 1) % gen_period;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input int period, input logic level);
        clk_x_a    = level;
        gen_phase  = 0;
        gen_period = period;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic gotoCycle(input int c);
        repeat (c - now) @(posedge clk_ref);
        @(negedge clk_ref);
        now = c;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        now        = 0;
        gen_period = 0;
        gen_phase  = 0;
        clk_x_a    = 1'b0;
        reset_a    = 1'b1;
        reset_b    = 1'b1;
        ready_a    = 1'b1;
        ready_b    = 1'b0;
        repeat (3) @(negedge clk_ref);

        checkOutput("reset_bcd_a",      32'(bcd_a),      32'h0);
        checkOutput("reset_overflow_a", 32'(overflow_a), 32'h0);
        checkOutput("reset_valid_a",    32'(valid_a),    32'h0);
        checkOutput("reset_bcd_b",      32'(bcd_b),      32'h0);
        checkOutput("reset_overflow_b", 32'(overflow_b), 32'h0);
        checkOutput("reset_valid_b",    32'(valid_b),    32'h0);

        reset_a = 1'b0;
        reset_b = 1'b0;
        #1 applyStimulus(10, 1'b0);

        gotoCycle(120);
        checkOutput("p10_valid_before_load", 32'(valid_a), 32'h0);
        gotoCycle(121);
        checkOutput("p10_valid",    32'(valid_a),    32'h1);
        checkOutput("p10_bcd",      32'(bcd_a),      32'h000010);
        checkOutput("p10_overflow", 32'(overflow_a), 32'h0);
        gotoCycle(122);
        checkOutput("p10_valid_pulse_end", 32'(valid_a), 32'h0);
        gotoCycle(221);
        checkOutput("p10_win2_valid", 32'(valid_a), 32'h1);
        checkOutput("p10_win2_bcd",   32'(bcd_a),   32'h000010);

        gotoCycle(230);
        #1 applyStimulus(0, 1'b1);
        gotoCycle(421);
        checkOutput("const1_valid",    32'(valid_a),    32'h1);
        checkOutput("const1_bcd",      32'(bcd_a),      32'h000000);
        checkOutput("const1_overflow", 32'(overflow_a), 32'h0);

        gotoCycle(425);
        #1 begin
            ready_a = 1'b0;
            applyStimulus(20, 1'b1);
        end
        gotoCycle(595);
        #1 applyStimulus(25, 1'b1);
        gotoCycle(621);
        checkOutput("stall_win5_valid", 32'(valid_a), 32'h1);
        checkOutput("stall_win5_bcd",   32'(bcd_a),   32'h000005);
        gotoCycle(695);
        #1 applyStimulus(50, 1'b0);
        gotoCycle(721);
        checkOutput("stall_win6_bcd", 32'(bcd_a), 32'h000004);
        gotoCycle(821);
        checkOutput("stall_win7_valid", 32'(valid_a), 32'h1);
        checkOutput("stall_win7_bcd",   32'(bcd_a),   32'h000002);

        gotoCycle(830);
        #1 ready_a = 1'b1;
        gotoCycle(831);
        checkOutput("accept_valid_cleared", 32'(valid_a), 32'h0);
        checkOutput("accept_bcd_held",      32'(bcd_a),   32'h000002);
        #1 ready_a = 1'b0;

        gotoCycle(900);
        #1 applyStimulus(10, 1'b0);
        gotoCycle(921);
        checkOutput("win8_bcd", 32'(bcd_a), 32'h000002);

        gotoCycle(997);
        #1 clk_x_a = 1'b1;

        gotoCycle(1010);
        checkOutput("sat_valid_before_load", 32'(valid_b), 32'h0);
        gotoCycle(1011);
        checkOutput("sat_valid",    32'(valid_b),    32'h1);
        checkOutput("sat_bcd",      32'(bcd_b),      32'h99);
        checkOutput("sat_overflow", 32'(overflow_b), 32'h1);

        gotoCycle(1021);
        checkOutput("terminal_edge_valid", 32'(valid_a), 32'h1);
        checkOutput("terminal_edge_bcd",   32'(bcd_a),   32'h000011);
        #1 ready_a = 1'b1;
        gotoCycle(1023);
        checkOutput("terminal_edge_accepted", 32'(valid_a), 32'h0);
        gotoCycle(1121);
        checkOutput("after_terminal_valid", 32'(valid_a), 32'h1);
        checkOutput("after_terminal_bcd",   32'(bcd_a),   32'h000010);
        gotoCycle(1122);
        checkOutput("after_terminal_pulse_end", 32'(valid_a), 32'h0);

        gotoCycle(1205);
        #1 reset_a = 1'b1;
        gotoCycle(1206);
        checkOutput("midshift_reset_bcd",      32'(bcd_a),      32'h0);
        checkOutput("midshift_reset_overflow", 32'(overflow_a), 32'h0);
        checkOutput("midshift_reset_valid",    32'(valid_a),    32'h0);
        reset_a = 1'b0;
        gotoCycle(1221);
        checkOutput("midshift_no_load", 32'(valid_a), 32'h0);
        gotoCycle(1326);
        checkOutput("post_reset_valid_early", 32'(valid_a), 32'h0);
        gotoCycle(1327);
        checkOutput("post_reset_valid", 32'(valid_a), 32'h1);
        checkOutput("post_reset_bcd",   32'(bcd_a),   32'h000010);
        checkOutput("stall_b_valid_held", 32'(valid_b), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
